// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO results and a start/busy/done handshake.
// Ports: clk, rst_n (async active-low), start, op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), a, b,
//        busy, done (one-cycle pulse), hi (product high / remainder), lo (product low / quotient), div_by_zero.
// Optional MULDIV_EARLY_OUT_EN: a multiply stops once the remaining multiplier magnitude is zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  localparam int CW = $clog2(WIDTH);
  logic [1:0]         state;
  logic               is_div, neg_p, neg_r, zflag;
  // mul: prod accumulates, mcand is |a| shifted left, mb is |b| shifted right
  // div: prod[WIDTH:0] is the partial remainder, mcand holds the divisor, mb shifts dividend out / quotient in
  logic [2*WIDTH-1:0] prod, mcand, prod_fix;
  logic [WIDTH-1:0]   mb, abs_a, abs_b, q_fix, r_fix;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     shl, diff;
  logic               sgn, b_zero, ge, last, last_mul;
  always_comb begin
    sgn      = ~op[0];
    b_zero   = b == '0;
    abs_a    = (sgn && a[WIDTH-1]) ? -a : a;
    abs_b    = (sgn && b[WIDTH-1]) ? -b : b;
    shl      = {prod[WIDTH-1:0], mb[WIDTH-1]};
    diff     = shl - {1'b0, mcand[WIDTH-1:0]};
    ge       = ~diff[WIDTH];
    last     = cnt == CW'(WIDTH - 1);
`ifdef MULDIV_EARLY_OUT_EN
    last_mul = last || mb[WIDTH-1:1] == '0;
`else
    last_mul = last;
`endif
    prod_fix = neg_p ? -prod : prod;
    q_fix    = neg_p ? -mb : mb;
    r_fix    = neg_r ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      is_div      <= 1'b0;
      neg_p       <= 1'b0;
      neg_r       <= 1'b0;
      zflag       <= 1'b0;
      prod        <= '0;
      mcand       <= '0;
      mb          <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state       <= (op[1] && b_zero) ? FIX : RUN;
          is_div      <= op[1];
          neg_p       <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r       <= sgn && a[WIDTH-1];
          zflag       <= op[1] && b_zero;
          div_by_zero <= 1'b0;
          prod        <= '0;
          cnt         <= '0;
          mcand       <= {{WIDTH{1'b0}}, op[1] ? abs_b : abs_a};
          // divide-by-zero keeps the raw dividend so hi can return it unmodified
          mb          <= op[1] ? (b_zero ? a : abs_a) : abs_b;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          prod  <= (2*WIDTH)'(ge ? diff : shl);
          mb    <= {mb[WIDTH-2:0], ge};
          state <= last ? FIX : RUN;
        end else begin
          prod  <= prod + (mb[0] ? mcand : '0);
          mcand <= mcand << 1;
          mb    <= mb >> 1;
          state <= last_mul ? FIX : RUN;
        end
      end else begin
        state <= IDLE;
        done  <= 1'b1;
        if (!is_div) begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end else if (zflag) begin
          hi          <= mb;
          lo          <= '1;
          div_by_zero <= 1'b1;
        end else begin
          hi <= r_fix;
          lo <= q_fix;
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, start = 0, busy, done, div_by_zero;
  logic [1:0] op = 0;
  logic [W-1:0] a = 0, b = 0, hi, lo;
  int npass = 0, ntot = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] eh, output logic [W-1:0] el, output logic ez);
    logic [63:0] p;
    ez = 0;
    if (!o[1]) begin
      p = o[0] ? {32'd0, x} * {32'd0, y} : 64'(longint'(signed'(x)) * longint'(signed'(y)));
      eh = p[63:32];
      el = p[31:0];
    end else if (y == 0) begin
      eh = x; el = '1; ez = 1;
    end else if (o[0]) begin
      el = x / y; eh = x % y;
    end else if (x == 32'h8000_0000 && y == '1) begin
      el = 32'h8000_0000; eh = 0;
    end else begin
      el = 32'(signed'(x) / signed'(y));
      eh = 32'(signed'(x) % signed'(y));
    end
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] m;
    int n;
    if (o[1]) return (y == 0) ? 1 : W + 1;
    m = (!o[0] && y[W-1]) ? -y : y;
    n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
    return n + 1;
`else
    return (n > 0) ? W + 1 : 0;
`endif
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    chk("busy_edge0", busy, 1);
  endtask

  task automatic wait_done(output int lat);
    logic bok = 1;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1 lat++;
      if (!done && !busy) bok = 0;
    end
    chk("busy_held", bok, 1);
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] eh, el;
    logic ez;
    int lat;
    model(o, x, y, eh, el, ez);
    start_op(o, x, y);
    wait_done(lat);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("dbz", div_by_zero, ez);
    chk("latency", lat, exp_lat(o, x, y));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk) rst_n = 1;
    run(2'b01, '1, '1);
    @(posedge clk);
    #1 chk("done_pulse_width", done, 0);
    run(2'b00, 32'hFFFF_FFFD, 7);
    run(2'b10, 32'h8000_0000, '1);
    run(2'b10, 32'hFFFF_FFF9, 2);
    run(2'b11, 100, 7);
    run(2'b11, 32'h1234, 0);
    run(2'b01, 2, 3);
    // start while busy is ignored
    start_op(2'b01, 6, 7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1; op = 2'b11; a = 9; b = 3;
    @(posedge clk);
    #1 start = 0;
    wait_done(lat);
    chk("ignored_lo", lo, 42);
    chk("ignored_hi", hi, 0);
    chk("ignored_lat", lat, exp_lat(2'b01, 6, 7) - 5);
    // start in the done cycle is accepted
    run(2'b11, 9, 3);
    // async reset mid-operation
    start_op(2'b00, 32'h1234_5678, 32'h0FED_CBA9);
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk) rst_n = 1;
    run(2'b01, 5, 5);
    run(2'b01, 9, 5);
    run(2'b01, 9, 0);
    run(2'b00, 32'h8000_0000, 32'h8000_0000);
    run(2'b10, 7, 32'hFFFF_FFFE);
    for (int i = 0; i < 250; i++) run(2'($urandom), pick(), pick());
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
